instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 157 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch stage with a small local instruction memory. After a
// start pulse it reads one 32-bit word per cycle from the current fetch
// pointer. The fetched word, its byte address and a valid flag are presented
// as registered outputs. The stage supports stall, branch redirect and a
// self-halt opcode. The instruction memory is loaded through a write port
// that is only honoured while the stage is not fetching.
//
// Parameters
//   IMEM_DEPTH    instruction-memory depth in 32-bit words (power of two, 4..256)
//   RESET_PC      byte address loaded into the fetch pointer and pc on reset
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous active-low reset
//   start         leave IDLE and begin fetching
//   stall         hold pc, instruction and instr_valid (downstream busy)
//   branch_taken  redirect the fetch pointer to branch_target (beats stall)
//   branch_target redirect byte address (low two bits ignored)
//   load_en       instruction-memory write strobe (IDLE/HALT only)
//   load_addr     word index for the write
//   load_data     word to write
//   instruction   registered fetched word
//   pc            byte address of the word in instruction
//   pc_plus4      pc + 4, modulo 2^32
//   instr_valid   instruction/pc hold a live fetch
//   halted        high while in HALT
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int          IMEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          stall,
  input  logic                          branch_taken,
  input  logic [31:0]                   branch_target,
  input  logic                          load_en,
  input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
  input  logic [31:0]                   load_data,
  output logic [31:0]                   instruction,
  output logic [31:0]                   pc,
  output logic [31:0]                   pc_plus4,
  output logic                          instr_valid,
  output logic                          halted
);

  localparam int AW = $clog2(IMEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] fpc_reg, fpc_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic        valid_reg, valid_next;

  logic [31:0] imem [IMEM_DEPTH];

  logic [AW-1:0] fetch_idx;
  logic [31:0]   fetch_word;
  logic          fetch_is_halt;

  // The word index is taken straight from the fetch pointer, so fetches wrap
  // modulo the memory depth without any extra logic.
  assign fetch_idx     = fpc_reg[AW+1:2];
  assign fetch_word    = imem[fetch_idx];
  assign fetch_is_halt = (fetch_word[31:26] == 6'b111111);

  // Instruction memory write port. Writes are blocked while fetching so a
  // write and a read of the same word can never collide. Contents survive
  // reset on purpose so a program can be reloaded-free restarted.
  always_ff @(posedge clk) begin
    if (load_en && (state_reg != FETCH)) begin
      imem[load_addr] <= load_data;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      fpc_reg   <= RESET_PC;
      pc_reg    <= RESET_PC;
      instr_reg <= 32'h0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      fpc_reg   <= fpc_next;
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
      valid_reg <= valid_next;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_next = state_reg;
    fpc_next   = fpc_reg;
    pc_next    = pc_reg;
    instr_next = instr_reg;
    valid_next = valid_reg;

    case (state_reg)
      IDLE: begin
        valid_next = 1'b0;
        if (start) begin
          state_next = FETCH;
        end
      end

      FETCH: begin
        if (branch_taken) begin
          // Redirect and drop the word currently presented; the masked
          // target forces word alignment while keeping every input bit used.
          fpc_next   = branch_target & 32'hFFFF_FFFC;
          valid_next = 1'b0;
        end else if (!stall) begin
          instr_next = fetch_word;
          pc_next    = fpc_reg;
          if (fetch_is_halt) begin
            // The halt word itself is shown but never marked valid, and the
            // pointer stays on it.
            valid_next = 1'b0;
            state_next = HALT;
          end else begin
            valid_next = 1'b1;
            fpc_next   = fpc_reg + 32'd4;
          end
        end
      end

      HALT: begin
        valid_next = 1'b0;
      end

      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
      end
    endcase
  end

  assign instruction = instr_reg;
  assign pc          = pc_reg;
  assign pc_plus4    = pc_reg + 32'd4;
  assign instr_valid = valid_reg;
  assign halted      = (state_reg == HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Scoreboard bench for instr_fetch_unit. Each scenario pushes the outputs it
// expects (tagged with the cycle they must appear on) into a queue; a monitor
// on the falling clock edge pops and compares them. Covers reset, basic
// fetch, stall, branch-over-stall flush, memory and address wrap, writes
// ignored during fetch, halt and exit from halt by reset.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic          branch_taken = 1'b0;
  logic [31:0]   branch_target = 32'h0;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [31:0]   load_data = 32'h0;
  logic [31:0]   instruction;
  logic [31:0]   pc;
  logic [31:0]   pc_plus4;
  logic          instr_valid;
  logic          halted;

  instr_fetch_unit #(
    .IMEM_DEPTH (DEPTH),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .load_en       (load_en),
    .load_addr     (load_addr),
    .load_data     (load_data),
    .instruction   (instruction),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .instr_valid   (instr_valid),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  int cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  typedef struct {
    string       tag;
    int          cyc;
    logic        full;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        halted;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_model [DEPTH];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Queue an expectation d clock edges from now (d >= 1).
  task automatic expect_out(input string tag, input int d, input logic full,
                            input logic [31:0] ins, input logic [31:0] p,
                            input logic v, input logic h);
    exp_t e;
    e.tag    = tag;
    e.cyc    = cycle_cnt + d;
    e.full   = full;
    e.instr  = ins;
    e.pc     = p;
    e.valid  = v;
    e.halted = h;
    sb.push_back(e);
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cycle_cnt) begin
      mon_e = sb.pop_front();
      if (mon_e.cyc != cycle_cnt) check_eq({mon_e.tag, "_late"}, cycle_cnt, mon_e.cyc);
      check_eq({mon_e.tag, "_valid"}, {31'b0, instr_valid}, {31'b0, mon_e.valid});
      check_eq({mon_e.tag, "_halted"}, {31'b0, halted}, {31'b0, mon_e.halted});
      if (mon_e.full) begin
        check_eq({mon_e.tag, "_instr"}, instruction, mon_e.instr);
        check_eq({mon_e.tag, "_pc"}, pc, mon_e.pc);
        check_eq({mon_e.tag, "_pc4"}, pc_plus4, mon_e.pc + 32'd4);
      end
      $display("[TB] cycle %0d %s: instr=%h pc=%h valid=%0b halted=%0b",
               cycle_cnt, mon_e.tag, instruction, pc, instr_valid, halted);
    end
  end

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic load_word(input int idx, input logic [31:0] data);
    mem_model[idx] = data;
    load_en   = 1'b1;
    load_addr = idx[AW-1:0];
    load_data = data;
    next_cycle();
    load_en   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset with outputs checked while reset is still asserted.
    repeat (3) next_cycle();
    expect_out("reset", 1, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
    next_cycle();
    reset = 1'b1;

    // Fill the whole memory so no fetch ever reads an unwritten word.
    for (int i = 0; i < DEPTH; i++) begin
      if (i < 3) load_word(i, 32'(i + 1));
      else       load_word(i, 32'h1000_0000 + 32'(i));
    end

    // Start, basic fetch, then a three-cycle stall while pc=4.
    start = 1'b1;
    expect_out("start_idle", 1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    expect_out("fetch0",     2, 1'b1, 32'h1, 32'h0, 1'b1, 1'b0);
    expect_out("fetch1",     3, 1'b1, 32'h2, 32'h4, 1'b1, 1'b0);
    expect_out("stall_a",    4, 1'b1, 32'h2, 32'h4, 1'b1, 1'b0);
    expect_out("stall_b",    5, 1'b1, 32'h2, 32'h4, 1'b1, 1'b0);
    expect_out("stall_c",    6, 1'b1, 32'h2, 32'h4, 1'b1, 1'b0);
    expect_out("fetch2",     7, 1'b1, 32'h3, 32'h8, 1'b1, 1'b0);
    next_cycle();
    start = 1'b0;
    next_cycle();
    next_cycle();
    stall = 1'b1;
    next_cycle();
    next_cycle();
    next_cycle();
    stall = 1'b0;
    next_cycle();

    // Branch beats stall; unaligned target is forced to a word boundary.
    branch_taken  = 1'b1;
    stall         = 1'b1;
    branch_target = 32'h23;
    expect_out("br_flush", 1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    expect_out("br_tgt",   2, 1'b1, mem_model[8], 32'h20, 1'b1, 1'b0);
    expect_out("br_tgt1",  3, 1'b1, mem_model[9], 32'h24, 1'b1, 1'b0);
    next_cycle();
    branch_taken = 1'b0;
    stall        = 1'b0;
    next_cycle();
    next_cycle();

    // Memory wrap at 0xFC -> 0x100, with write attempts during FETCH.
    branch_taken  = 1'b1;
    branch_target = 32'hFC;
    load_en       = 1'b1;
    load_addr     = '0;
    load_data     = 32'hDEAD_BEEF;
    expect_out("wrap_flush", 1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    expect_out("wrap63",     2, 1'b1, mem_model[63], 32'hFC,  1'b1, 1'b0);
    expect_out("wrap0",      3, 1'b1, mem_model[0],  32'h100, 1'b1, 1'b0);
    expect_out("wrap1",      4, 1'b1, mem_model[1],  32'h104, 1'b1, 1'b0);
    next_cycle();
    branch_taken = 1'b0;
    load_addr    = 6'd1;
    load_data    = 32'hCAFE_F00D;
    next_cycle();
    load_en = 1'b0;
    next_cycle();
    next_cycle();

    // 32-bit address wrap: 0xFFFF_FFFC -> 0, pc_plus4 wraps to 0.
    branch_taken  = 1'b1;
    branch_target = 32'hFFFF_FFFF;
    expect_out("top_flush", 1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    expect_out("top_fc",    2, 1'b1, mem_model[63], 32'hFFFF_FFFC, 1'b1, 1'b0);
    expect_out("top_wrap",  3, 1'b1, mem_model[0],  32'h0,         1'b1, 1'b0);
    next_cycle();
    branch_taken = 1'b0;
    next_cycle();
    next_cycle();

    // Reset mid-fetch, overriding stall and branch.
    reset        = 1'b0;
    stall        = 1'b1;
    branch_taken = 1'b1;
    expect_out("rst_mid", 1, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
    next_cycle();
    reset        = 1'b1;
    stall        = 1'b0;
    branch_taken = 1'b0;
    load_word(3, 32'hFC00_0000);

    // Run into the halt word at index 3; memory survived the reset.
    start = 1'b1;
    expect_out("h_idle", 1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    expect_out("h_f0",   2, 1'b1, 32'h1, 32'h0, 1'b1, 1'b0);
    expect_out("h_f1",   3, 1'b1, 32'h2, 32'h4, 1'b1, 1'b0);
    expect_out("h_f2",   4, 1'b1, 32'h3, 32'h8, 1'b1, 1'b0);
    expect_out("halt",   5, 1'b1, 32'hFC00_0000, 32'hC, 1'b0, 1'b1);
    next_cycle();
    start = 1'b0;
    repeat (4) next_cycle();

    // HALT ignores start and branch_taken.
    start         = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    expect_out("halt_hold1", 1, 1'b1, 32'hFC00_0000, 32'hC, 1'b0, 1'b1);
    expect_out("halt_hold2", 2, 1'b1, 32'hFC00_0000, 32'hC, 1'b0, 1'b1);
    next_cycle();
    next_cycle();

    // One-cycle reset leaves HALT for IDLE, which then stays put.
    reset        = 1'b0;
    start        = 1'b0;
    branch_taken = 1'b0;
    expect_out("rst_halt", 1, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
    next_cycle();
    reset = 1'b1;
    expect_out("idle_stay",  1, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
    expect_out("idle_stay2", 2, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
    next_cycle();
    next_cycle();
    next_cycle();

    check_eq("sb_drain", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
